// File: rtl/id_stage_pkg.sv
// Shared decode constants for the MIPS ID stage: opcodes, functs, ALU op encoding
// and the internal control bundle produced by the decoder.
package id_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] RA_REG = 5'd31;

    // ALU_LUI passes operand B through; the immediate is already shifted.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {BR_NONE = 2'd0, BR_EQ = 2'd1, BR_NE = 2'd2} branch_e;
    typedef enum logic [1:0] {JMP_NONE = 2'd0, JMP_J = 2'd1, JMP_JR = 2'd2} jump_e;
    typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2} dst_sel_e;

    typedef struct packed {
        alu_op_e  alu_op;
        logic     alu_src;
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     mem_to_reg;
        branch_e  branch;
        jump_e    jump;
        dst_sel_e dst_sel;
        logic     reads_rt;
        logic     illegal;
    } ctrl_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// Two-read, one-write architectural register file; register 0 reads as zero.
// Optional write-before-read bypass under WB_BYPASS_EN.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int REG_NUM = 32,
    parameter int ADDR_W = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs [REG_NUM];
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (addr == '0) begin
            return '0;
        end
        if (BYPASS && wr_live && (wr_addr == addr)) begin
            return wr_data;
        end
        return regs[addr];
    endfunction

    assign rd_data_a = read_port(rd_addr_a);
    assign rd_data_b = read_port(rd_addr_b);

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, decoder, load-use stall, targets.
// Define WB_BYPASS_EN to let a same-cycle WB write appear on the read ports.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_NUM = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       Ins,
    input  logic [31:0]       nextPC,
    input  logic              Flush,
    input  logic              EX_MemRead,
    input  logic [4:0]        EX_Rt,
    input  logic              WB_WE,
    input  logic [4:0]        WB_Rd,
    input  logic [DATA_W-1:0] WB_Data,
    output logic              Stall,
    output logic              ID_Valid,
    output logic [31:0]       ID_nextPC,
    output logic [DATA_W-1:0] ID_RsData,
    output logic [DATA_W-1:0] ID_RtData,
    output logic [31:0]       ID_Imm,
    output logic [4:0]        ID_Rs,
    output logic [4:0]        ID_Rt,
    output logic [4:0]        ID_Dst,
    output logic [3:0]        ID_ALUOp,
    output logic              ID_ALUSrc,
    output logic              ID_RegWrite,
    output logic              ID_MemRead,
    output logic              ID_MemWrite,
    output logic              ID_MemToReg,
    output logic [1:0]        ID_Branch,
    output logic [1:0]        ID_Jump,
    output logic [31:0]       ID_BrTarget,
    output logic [31:0]       ID_JTarget,
    output logic              ID_Illegal
);

    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        stall;
    logic        live;
    ctrl_t       ctrl;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] imm_sext;

    assign opcode   = if_ins[31:26];
    assign rs       = if_ins[25:21];
    assign rt       = if_ins[20:16];
    assign rd       = if_ins[15:11];
    assign funct    = if_ins[5:0];
    assign imm      = if_ins[15:0];
    assign imm_sext = sign_ext16(imm);

    // Flush beats stall so a wrong-path instruction never survives a hold.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            if_valid <= 1'b0;
            if_ins   <= '0;
            if_pc    <= '0;
        end else if (Flush) begin
            if_valid <= 1'b0;
            if_ins   <= '0;
        end else if (!stall) begin
            if_valid <= 1'b1;
            if_ins   <= Ins;
            if_pc    <= nextPC;
        end
    end

    always_comb begin
        ctrl          = '0;
        ctrl.alu_op   = ALU_ADD;
        ctrl.branch   = BR_NONE;
        ctrl.jump     = JMP_NONE;
        ctrl.dst_sel  = DST_RT;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl.dst_sel   = DST_RD;
                ctrl.reads_rt  = 1'b1;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD: ctrl.alu_op = ALU_ADD;
                    FN_SUB: ctrl.alu_op = ALU_SUB;
                    FN_AND: ctrl.alu_op = ALU_AND;
                    FN_OR:  ctrl.alu_op = ALU_OR;
                    FN_SLT: ctrl.alu_op = ALU_SLT;
                    FN_SLL: ctrl.alu_op = ALU_SLL;
                    FN_SRL: ctrl.alu_op = ALU_SRL;
                    FN_JR: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.jump      = JMP_JR;
                    end
                    default: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_ANDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
            OP_ORI:  begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR; end
            OP_LUI:  begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_LUI; end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW:  begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; ctrl.reads_rt = 1'b1; end
            OP_BEQ: begin ctrl.alu_op = ALU_SUB; ctrl.branch = BR_EQ; ctrl.reads_rt = 1'b1; end
            OP_BNE: begin ctrl.alu_op = ALU_SUB; ctrl.branch = BR_NE; ctrl.reads_rt = 1'b1; end
            OP_J:   ctrl.jump = JMP_J;
            OP_JAL: begin ctrl.jump = JMP_J; ctrl.reg_write = 1'b1; ctrl.dst_sel = DST_RA; end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    assign stall = if_valid && EX_MemRead && (EX_Rt != 5'd0) &&
                   ((EX_Rt == rs) || (ctrl.reads_rt && (EX_Rt == rt)));
    assign live  = if_valid && !stall;

    always_comb begin
        ID_Imm = imm_sext;
        if (opcode == OP_ANDI || opcode == OP_ORI) begin
            ID_Imm = {16'b0, imm};
        end else if (opcode == OP_LUI) begin
            ID_Imm = {imm, 16'b0};
        end
    end

    always_comb begin
        ID_Dst = rt;
        if (ctrl.dst_sel == DST_RD) begin
            ID_Dst = rd;
        end else if (ctrl.dst_sel == DST_RA) begin
            ID_Dst = RA_REG;
        end
    end

    reg_file #(.DATA_W(DATA_W), .REG_NUM(REG_NUM)) u_reg_file (
        .clk       (CLK),
        .rst_n     (RST),
        .rd_addr_a (rs),
        .rd_addr_b (rt),
        .rd_data_a (ID_RsData),
        .rd_data_b (ID_RtData),
        .wr_en     (WB_WE),
        .wr_addr   (WB_Rd),
        .wr_data   (WB_Data)
    );

    // A stalled slot leaves as a bubble: nothing downstream may write or redirect.
    assign Stall       = stall;
    assign ID_Valid    = live;
    assign ID_nextPC   = if_pc;
    assign ID_Rs       = rs;
    assign ID_Rt       = rt;
    assign ID_ALUOp    = ctrl.alu_op;
    assign ID_ALUSrc   = ctrl.alu_src;
    assign ID_RegWrite = live && ctrl.reg_write;
    assign ID_MemRead  = live && ctrl.mem_read;
    assign ID_MemWrite = live && ctrl.mem_write;
    assign ID_MemToReg = live && ctrl.mem_to_reg;
    assign ID_Branch   = live ? ctrl.branch : BR_NONE;
    assign ID_Jump     = live ? ctrl.jump : JMP_NONE;
    assign ID_BrTarget = if_pc + {imm_sext[29:0], 2'b00};
    assign ID_JTarget  = {if_pc[31:28], if_ins[25:0], 2'b00};
    assign ID_Illegal  = if_valid && ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus queues hand-computed decodes, a negedge
// monitor pops one entry per valid ID output. Honours WB_BYPASS_EN.
module tb_id_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Ins, nextPC, WB_Data;
    logic        Flush, EX_MemRead, WB_WE;
    logic [4:0]  EX_Rt, WB_Rd;
    logic        Stall, ID_Valid, ID_ALUSrc, ID_RegWrite, ID_MemRead, ID_MemWrite;
    logic        ID_MemToReg, ID_Illegal;
    logic [31:0] ID_nextPC, ID_RsData, ID_RtData, ID_Imm, ID_BrTarget, ID_JTarget;
    logic [4:0]  ID_Rs, ID_Rt, ID_Dst;
    logic [3:0]  ID_ALUOp;
    logic [1:0]  ID_Branch, ID_Jump;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'd9;
`else
    localparam logic [31:0] BYP_EXP = 32'd20;
`endif

    typedef struct {
        string       name;
        logic [31:0] pc, rs, rt, imm, tgt;
        logic [4:0]  dst;
        logic [3:0]  aluop;
        logic [5:0]  ctl;
        logic [1:0]  br, jmp;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;

    id_stage #(.DATA_W(32), .REG_NUM(32)) dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .nextPC(nextPC), .Flush(Flush),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .WB_WE(WB_WE), .WB_Rd(WB_Rd),
        .WB_Data(WB_Data), .Stall(Stall), .ID_Valid(ID_Valid), .ID_nextPC(ID_nextPC),
        .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm(ID_Imm), .ID_Rs(ID_Rs),
        .ID_Rt(ID_Rt), .ID_Dst(ID_Dst), .ID_ALUOp(ID_ALUOp), .ID_ALUSrc(ID_ALUSrc),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemToReg(ID_MemToReg), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump),
        .ID_BrTarget(ID_BrTarget), .ID_JTarget(ID_JTarget), .ID_Illegal(ID_Illegal)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // ctl bit order: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Illegal}
    task automatic push_exp(input string name, input logic [31:0] pc, rs, rt,
                            input logic [4:0] dst, input logic [31:0] imm,
                            input logic [3:0] aluop, input logic [5:0] ctl,
                            input logic [1:0] br, jmp, input logic [31:0] tgt);
        exp_t e;
        e.name = name; e.pc = pc; e.rs = rs; e.rt = rt; e.dst = dst; e.imm = imm;
        e.aluop = aluop; e.ctl = ctl; e.br = br; e.jmp = jmp; e.tgt = tgt;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b1 && ID_Valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                cur = sb.pop_front();
                checkOutput({cur.name, ".pc"}, ID_nextPC, cur.pc);
                checkOutput({cur.name, ".rs"}, ID_RsData, cur.rs);
                checkOutput({cur.name, ".rt"}, ID_RtData, cur.rt);
                checkOutput({cur.name, ".dst"}, {27'b0, ID_Dst}, {27'b0, cur.dst});
                checkOutput({cur.name, ".imm"}, ID_Imm, cur.imm);
                checkOutput({cur.name, ".aluop"}, {28'b0, ID_ALUOp}, {28'b0, cur.aluop});
                checkOutput({cur.name, ".ctl"},
                            {26'b0, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_Illegal},
                            {26'b0, cur.ctl});
                checkOutput({cur.name, ".brjmp"}, {28'b0, ID_Branch, ID_Jump}, {28'b0, cur.br, cur.jmp});
                if (cur.br != 2'd0) checkOutput({cur.name, ".brtgt"}, ID_BrTarget, cur.tgt);
                if (cur.jmp != 2'd0) checkOutput({cur.name, ".jtgt"}, ID_JTarget, cur.tgt);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] ins, pc, input logic flush, exmr,
                                 input logic [4:0] exrt, input logic we,
                                 input logic [4:0] rd, input logic [31:0] data);
        Ins = ins; nextPC = pc; Flush = flush; EX_MemRead = exmr; EX_Rt = exrt;
        WB_WE = we; WB_Rd = rd; WB_Data = data;
        #2;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] bench timed out");
    end

    initial begin
        RST = 1'b0;
        Ins = '0; nextPC = '0; Flush = 1'b1; EX_MemRead = 1'b0; EX_Rt = '0;
        WB_WE = 1'b0; WB_Rd = '0; WB_Data = '0;
        #3;
        checkOutput("reset_valid", {31'b0, ID_Valid}, 32'd0);
        checkOutput("reset_stall", {31'b0, Stall}, 32'd0);
        checkOutput("reset_regwrite", {31'b0, ID_RegWrite}, 32'd0);
        checkOutput("reset_memwrite", {31'b0, ID_MemWrite}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        step();

        applyStimulus(32'h0, 32'h0, 1, 0, 0, 1, 5'd1, 32'd5);  step();
        applyStimulus(32'h0, 32'h0, 1, 0, 0, 1, 5'd2, 32'd7);  step();
        applyStimulus(32'h0, 32'h0, 1, 0, 0, 1, 5'd4, 32'd11); step();
        applyStimulus(32'h0, 32'h0, 1, 0, 0, 1, 5'd6, 32'd3);  step();
        applyStimulus(32'h0, 32'h0, 1, 0, 0, 1, 5'd7, 32'd20); step();

        push_exp("add3", 32'h104, 5, 7, 5'd3, 32'h1820, 4'd0, 6'b100000, 0, 0, 0);
        applyStimulus(32'h00221820, 32'h104, 0, 0, 0, 0, 0, 0); step();
        push_exp("sub5", 32'h208, 11, 3, 5'd5, 32'h2822, 4'd1, 6'b100000, 0, 0, 0);
        applyStimulus(32'h00862822, 32'h208, 0, 0, 0, 0, 0, 0); step();

        applyStimulus(32'h34288001, 32'h20C, 0, 1, 5'd4, 0, 0, 0);
        checkOutput("loaduse_stall", {31'b0, Stall}, 32'd1);
        checkOutput("loaduse_bubble_valid", {31'b0, ID_Valid}, 32'd0);
        checkOutput("loaduse_bubble_rw", {31'b0, ID_RegWrite}, 32'd0);
        step();
        push_exp("ori8", 32'h20C, 5, 0, 5'd8, 32'h8001, 4'd3, 6'b100010, 0, 0, 0);
        applyStimulus(32'h34288001, 32'h20C, 0, 0, 0, 0, 0, 0);
        checkOutput("loaduse_released", {31'b0, Stall}, 32'd0);
        checkOutput("loaduse_held_valid", {31'b0, ID_Valid}, 32'd1);
        step();

        push_exp("beq", 32'h100, 5, 7, 5'd2, 32'hFFFFFFFF, 4'd1, 6'b000000, 1, 0, 32'hFC);
        applyStimulus(32'h1022FFFF, 32'h100, 0, 0, 0, 0, 0, 0); step();
        push_exp("jal", 32'h20000008, 0, 0, 5'd31, 32'h40, 4'd0, 6'b100000, 0, 1, 32'h20000100);
        applyStimulus(32'h0C000040, 32'h20000008, 0, 0, 0, 0, 0, 0); step();
        push_exp("lui9", 32'h300, 0, 0, 5'd9, 32'h12340000, 4'd7, 6'b100010, 0, 0, 0);
        applyStimulus(32'h3C091234, 32'h300, 0, 0, 0, 0, 0, 0); step();
        push_exp("sw", 32'h304, 5, 7, 5'd2, 32'hFFFFFFFC, 4'd0, 6'b001010, 0, 0, 0);
        applyStimulus(32'hAC22FFFC, 32'h304, 0, 0, 0, 0, 0, 0); step();
        push_exp("lw13", 32'h308, 7, 0, 5'd13, 32'h8, 4'd0, 6'b110110, 0, 0, 0);
        applyStimulus(32'h8C4D0008, 32'h308, 0, 0, 0, 0, 0, 0); step();
        push_exp("illegal", 32'h30C, 0, 0, 5'd0, 32'h0, 4'd0, 6'b000001, 0, 0, 0);
        applyStimulus(32'hFC000000, 32'h30C, 0, 0, 0, 0, 0, 0); step();

        applyStimulus(32'h0, 32'h0, 1, 0, 0, 1, 5'd0, 32'hDEAD); step();
        push_exp("add10_r0", 32'h310, 0, 0, 5'd10, 32'h5020, 4'd0, 6'b100000, 0, 0, 0);
        applyStimulus(32'h00005020, 32'h310, 0, 0, 0, 0, 0, 0); step();
        push_exp("add11_byp", 32'h314, BYP_EXP, 0, 5'd11, 32'h5820, 4'd0, 6'b100000, 0, 0, 0);
        applyStimulus(32'h00E05820, 32'h314, 0, 0, 0, 0, 0, 0); step();
        push_exp("add12_new", 32'h318, 9, 0, 5'd12, 32'h6020, 4'd0, 6'b100000, 0, 0, 0);
        applyStimulus(32'h00E06020, 32'h318, 0, 0, 0, 1, 5'd7, 32'd9); step();
        applyStimulus(32'h0, 32'h0, 1, 0, 0, 0, 0, 0); step();

        applyStimulus(32'h00862822, 32'h404, 0, 0, 0, 0, 0, 0); step();
        applyStimulus(32'h00221820, 32'h408, 1, 1, 5'd4, 0, 0, 0);
        checkOutput("flushstall_stall", {31'b0, Stall}, 32'd1);
        step();
        applyStimulus(32'h00221820, 32'h40C, 1, 0, 0, 0, 0, 0);
        checkOutput("flushstall_valid", {31'b0, ID_Valid}, 32'd0);
        checkOutput("flushstall_ins_imm", ID_Imm, 32'd0);
        checkOutput("flushstall_ins_rt", {27'b0, ID_Rt}, 32'd0);
        step();

        applyStimulus(32'h00221820, 32'h500, 0, 0, 0, 0, 0, 0); step();
        checkOutput("prereset_valid", {31'b0, ID_Valid}, 32'd1);
        checkOutput("prereset_rs", ID_RsData, 32'd5);
        RST = 1'b0;
        #1;
        checkOutput("async_reset_valid", {31'b0, ID_Valid}, 32'd0);
        checkOutput("async_reset_rs", ID_RsData, 32'd0);
        checkOutput("async_reset_rw", {31'b0, ID_RegWrite}, 32'd0);
        applyStimulus(32'h0, 32'h0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;
        step();
        step();

        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
